// File: rtl/life_gen_scheduler.sv
// 8x8 Game of Life generation scheduler: paces generations off vsync or single steps,
// sweeps one cell per cycle from a snapshot and commits the whole board at once.
module life_gen_scheduler #(
    parameter int unsigned FRAMES_PER_GEN = 2,
    parameter logic [63:0] SEED           = 64'h0A28_0A28_1402_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        run,
    input  logic        step,
    input  logic        load,
    output logic [63:0] board_out,
    output logic        busy,
    output logic        gen_done,
    output logic [15:0] gen_count,
    output logic        extinct
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SNAP   = 2'd1;
    localparam logic [1:0] S_SWEEP  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_GEN - 1);
    localparam logic       SEED_DEAD  = (SEED == 64'd0);

    logic [1:0]  state,     state_d;
    logic        vsync_q;
    logic        trig_q,    trig_d;
    logic [5:0]  frame_cnt, frame_cnt_d;
    logic [5:0]  idx,       idx_d;
    logic [63:0] prev,      prev_d;
    logic [63:0] next_gen,  next_gen_d;
    logic [63:0] board_d;
    logic [15:0] gen_count_d;
    logic        gen_done_d, busy_d, extinct_d;
    logic        vs_edge;
    logic [3:0]  nbr_cnt;
    logic        cell_next;

    // Live neighbours of cell i in board b; off-board positions count as dead.
    function automatic logic [3:0] count_nbrs(input logic [63:0] b, input logic [5:0] i);
        logic [3:0] n;
        int r;
        int c;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(i[5:3]) + dr;
                c = int'(i[2:0]) + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8)
                    n = n + 4'(b[6'(r * 8 + c)]);
            end
        end
        return n;
    endfunction

    assign vs_edge   = vsync & ~vsync_q;
    assign nbr_cnt   = count_nbrs(prev, idx);
    assign cell_next = prev[idx] ? (nbr_cnt == 4'd2 || nbr_cnt == 4'd3) : (nbr_cnt == 4'd3);

    always_comb begin
        state_d     = state;
        trig_d      = 1'b0;
        frame_cnt_d = frame_cnt;
        idx_d       = idx;
        prev_d      = prev;
        next_gen_d  = next_gen;
        board_d     = board_out;
        gen_count_d = gen_count;
        gen_done_d  = 1'b0;
        extinct_d   = extinct;

        case (state)
            S_IDLE: begin
                if (run && vs_edge) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt_d = 6'd0;
                        trig_d      = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt + 6'd1;
                    end
                end
                if (step)
                    trig_d = 1'b1;
                if (trig_q)
                    state_d = S_SNAP;
            end
            S_SNAP: begin
                prev_d  = board_out;
                idx_d   = 6'd0;
                state_d = S_SWEEP;
            end
            S_SWEEP: begin
                next_gen_d[idx] = cell_next;
                idx_d           = idx + 6'd1;
                if (idx == 6'd63)
                    state_d = S_COMMIT;
            end
            default: begin
                board_d     = next_gen;
                gen_count_d = gen_count + 16'd1;
                gen_done_d  = 1'b1;
                extinct_d   = (next_gen == 64'd0);
                state_d     = S_IDLE;
            end
        endcase

        // Reload overrides everything, including an in-flight generation.
        if (load) begin
            board_d     = SEED;
            gen_count_d = 16'd0;
            frame_cnt_d = 6'd0;
            extinct_d   = SEED_DEAD;
            gen_done_d  = 1'b0;
            trig_d      = 1'b0;
            state_d     = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    // vsync_q resets high so a vsync already high at release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            vsync_q   <= 1'b1;
            trig_q    <= 1'b0;
            frame_cnt <= 6'd0;
            idx       <= 6'd0;
            prev      <= 64'd0;
            next_gen  <= 64'd0;
            board_out <= SEED;
            gen_count <= 16'd0;
            gen_done  <= 1'b0;
            busy      <= 1'b0;
            extinct   <= SEED_DEAD;
        end else begin
            state     <= state_d;
            vsync_q   <= vsync;
            trig_q    <= trig_d;
            frame_cnt <= frame_cnt_d;
            idx       <= idx_d;
            prev      <= prev_d;
            next_gen  <= next_gen_d;
            board_out <= board_d;
            gen_count <= gen_count_d;
            gen_done  <= gen_done_d;
            busy      <= busy_d;
            extinct   <= extinct_d;
        end
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: directed pacing/abort scenarios plus randomized
// step/vsync traffic checked against a whole-board Life model.
module tb_life_gen_scheduler;

    localparam logic [63:0] SEED_A = 64'h0A28_0A28_1402_0000;

    logic        clk = 1'b0;
    logic        reset, vsync, run, step, load, step_x;
    logic [63:0] board_out, board_x;
    logic        busy, gen_done, extinct, busy_x, done_x, extinct_x;
    logic [15:0] gen_count, count_x;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_board;
    int          m_count;
    int          m_fc;

    always #5 clk = ~clk;

    life_gen_scheduler #(.FRAMES_PER_GEN(3)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .run(run), .step(step), .load(load),
        .board_out(board_out), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count), .extinct(extinct)
    );

    life_gen_scheduler #(.FRAMES_PER_GEN(1), .SEED(64'h1)) dut_x (
        .clk(clk), .reset(reset), .vsync(1'b0), .run(1'b0), .step(step_x), .load(1'b0),
        .board_out(board_x), .busy(busy_x), .gen_done(done_x),
        .gen_count(count_x), .extinct(extinct_x)
    );

    // Reference generation on a zero-padded 10x10 grid.
    function automatic logic [63:0] life(input logic [63:0] b);
        int g[0:9][0:9];
        int n;
        logic [63:0] r;
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                g[y][x] = 0;
        for (int i = 0; i < 64; i++)
            g[i / 8 + 1][i % 8 + 1] = int'(b[6'(i)]);
        r = 64'd0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                n = g[y-1][x-1] + g[y-1][x] + g[y-1][x+1] + g[y][x-1]
                  + g[y][x+1] + g[y+1][x-1] + g[y+1][x] + g[y+1][x+1];
                r[6'((y - 1) * 8 + (x - 1))] = (n == 3) || (g[y][x] == 1 && n == 2);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts gen_done cycles over a bounded window; lat = first pulse cycle after capture.
    task automatic window(output int pulses, output int lat);
        pulses = 0;
        lat    = -1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (gen_done) begin
                pulses++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    task automatic do_edge(output int pulses, output int lat);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        window(pulses, lat);
    endtask

    task automatic do_step(output int pulses, output int lat);
        step = 1'b1;
        tick();
        step = 1'b0;
        window(pulses, lat);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_board"}, board_out, m_board);
        chk({tag, "_count"}, 64'(gen_count), 64'(m_count));
        chk({tag, "_extinct"}, 64'(extinct), 64'(m_board == 64'd0));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int p, lat, exp_p, act;

        reset = 1'b1; vsync = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0; step_x = 1'b0;
        repeat (3) tick();
        m_board = SEED_A; m_count = 0; m_fc = 0;
        chk_state("reset");
        chk("reset_gen_done", 64'(gen_done), 64'd0);
        chk("reset_x_board", board_x, 64'h1);
        chk("reset_x_extinct", 64'(extinct_x), 64'd0);

        // Release with vsync high: no edge may be counted.
        reset = 1'b0; run = 1'b1;
        repeat (5) tick();
        vsync = 1'b0;
        tick();

        // Divider: generations on every third edge only.
        for (int e = 0; e < 9; e++) begin
            do_edge(p, lat);
            exp_p = (e % 3 == 2) ? 1 : 0;
            chk($sformatf("div_edge%0d_pulses", e), 64'(p), 64'(exp_p));
            if (exp_p == 1) begin
                m_board = life(m_board); m_count++;
                chk($sformatf("div_edge%0d_latency", e), 64'(lat), 64'd67);
            end
            chk_state($sformatf("div_edge%0d", e));
        end

        run = 1'b0;
        for (int e = 0; e < 4; e++) begin
            do_edge(p, lat);
            chk($sformatf("norun_edge%0d_pulses", e), 64'(p), 64'd0);
        end
        chk_state("norun");

        do_step(p, lat);
        m_board = life(m_board); m_count++;
        chk("step_pulses", 64'(p), 64'd1);
        chk("step_latency", 64'(lat), 64'd67);
        chk_state("step");

        // Randomized mix of steps and vsync edges.
        for (int it = 0; it < 30; it++) begin
            act = int'($urandom_range(0, 2));
            run = 1'($urandom_range(0, 1));
            exp_p = 0;
            if (act == 0) begin
                do_step(p, lat);
                exp_p = 1;
            end else if (act == 1) begin
                do_edge(p, lat);
                if (run) begin
                    m_fc++;
                    if (m_fc == 3) begin
                        m_fc = 0;
                        exp_p = 1;
                    end
                end
            end else begin
                repeat (int'($urandom_range(1, 20))) tick();
                p = 0;
            end
            if (exp_p == 1) begin
                m_board = life(m_board); m_count++;
            end
            chk($sformatf("rand%0d_pulses", it), 64'(p), 64'(exp_p));
            chk_state($sformatf("rand%0d", it));
        end

        // Load aborts a sweep at idx 30; a step while busy is ignored.
        run = 1'b0;
        step = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
            step = (k == 10);
            tick();
        end
        step = 1'b0;
        chk("preload_busy", 64'(busy), 64'd1);
        load = 1'b1;
        tick();
        load = 1'b0;
        m_board = SEED_A; m_count = 0; m_fc = 0;
        chk("load_gen_done", 64'(gen_done), 64'd0);
        chk_state("load");
        window(p, lat);
        chk("load_after_pulses", 64'(p), 64'd0);
        chk_state("load_after");

        do_step(p, lat);
        m_board = life(m_board); m_count++;
        chk("postload_pulses", 64'(p), 64'd1);
        chk_state("postload");

        // Asynchronous reset mid-sweep with vsync held high through release.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (20) tick();
        chk("prereset_busy", 64'(busy), 64'd1);
        vsync = 1'b1;
        reset = 1'b1;
        #1;
        m_board = SEED_A; m_count = 0; m_fc = 0;
        chk("async_reset_gen_done", 64'(gen_done), 64'd0);
        chk_state("async_reset");
        tick(); tick();
        reset = 1'b0; run = 1'b1;
        window(p, lat);
        chk("release_pulses", 64'(p), 64'd0);
        chk_state("release");
        vsync = 1'b0;
        tick();
        for (int e = 0; e < 3; e++) begin
            do_edge(p, lat);
            exp_p = (e == 2) ? 1 : 0;
            chk($sformatf("rel_edge%0d_pulses", e), 64'(p), 64'(exp_p));
        end
        m_board = life(m_board); m_count++;
        chk_state("rel_edges");

        // Single cell dies and the board stays extinct while counting continues.
        for (int s = 1; s <= 2; s++) begin
            step_x = 1'b1;
            tick();
            step_x = 1'b0;
            p = 0;
            for (int n = 1; n <= 80; n++) begin
                tick();
                if (done_x) p++;
            end
            chk($sformatf("x_step%0d_pulses", s), 64'(p), 64'd1);
            chk($sformatf("x_step%0d_board", s), board_x, 64'd0);
            chk($sformatf("x_step%0d_extinct", s), 64'(extinct_x), 64'd1);
            chk($sformatf("x_step%0d_count", s), 64'(count_x), 64'(s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/life_gen_scheduler.md
LIFE_GEN_SCHEDULER -- requirements
Module: life_gen_scheduler

Interface
REQ-001 SHALL have parameter FRAMES_PER_GEN, default 2: vsync rising edges per generation while running (legal range 1..63).
REQ-002 SHALL have parameter SEED, default 64'h0A28_0A28_1402_0000: initial 8x8 board; bit i is cell i; row = i/8, column = i%8.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port vsync, input, 1 bit: raw VGA vsync level, sampled on clk.
REQ-006 SHALL have port run, input, 1 bit: level; 1 = free-running generations.
REQ-007 SHALL have port step, input, 1 bit: 1-cycle pulse requesting one generation.
REQ-008 SHALL have port load, input, 1 bit: 1-cycle pulse that restores SEED.
REQ-009 SHALL have port board_out, output, 64 bits: committed board for display.
REQ-010 SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-011 SHALL have port gen_done, output, 1 bit: 1-cycle pulse when a generation commits.
REQ-012 SHALL have port gen_count, output, 16 bits: committed generations since reset or load.
REQ-013 SHALL have port extinct, output, 1 bit: registered flag, 1 when board_out == 0.

Function
REQ-014 SHALL detect a vsync edge as vsync==1 with the registered previous sample vsync_q==0.
REQ-015 SHALL count vsync edges in frame_cnt (6 bits) only when run==1 and state==IDLE; edges in other states are dropped, not queued.
REQ-016 SHALL raise an internal trigger when an edge arrives with frame_cnt==FRAMES_PER_GEN-1, and SHALL clear frame_cnt to 0 in the same cycle.
REQ-017 SHALL raise the trigger on step==1 in IDLE regardless of run; step outside IDLE SHALL be ignored.
REQ-018 SHALL implement the FSM IDLE -> SNAP -> SWEEP -> COMMIT -> IDLE.
REQ-019 IDLE SHALL go to SNAP on the cycle after the trigger.
REQ-020 SNAP SHALL copy board_out into the 64-bit prev snapshot, clear idx (6 bits) to 0, and go to SWEEP.
REQ-021 SWEEP SHALL evaluate one cell per cycle at idx, write the result into next[idx], and increment idx.
REQ-022 SWEEP SHALL go to COMMIT after evaluating idx==63, giving exactly 64 SWEEP cycles.
REQ-023 COMMIT SHALL, in one cycle: set board_out<=next, gen_count<=gen_count+1 (wrapping 16'hFFFF->0), pulse gen_done, update extinct from next, then go to IDLE.
REQ-024 Trigger-to-gen_done latency SHALL be 67 cycles: 1 cycle to enter SNAP, then SNAP 1, SWEEP 64, COMMIT 1.
REQ-025 board_out SHALL change only in COMMIT, reset or load; the display never sees a partial generation.
REQ-026 The neighbour count SHALL be 4 bits, 0..8, taken from prev only.
REQ-027 Edges SHALL NOT wrap: cells outside rows 0..7 or columns 0..7 count as dead.
REQ-028 Next-state rule: a live cell survives with 2 or 3 neighbours; a dead cell is born with exactly 3; otherwise the cell is dead.
REQ-029 load SHALL have highest priority in any state: abort any sweep, board_out<=SEED, gen_count<=0, frame_cnt<=0, extinct<=(SEED==0), state<=IDLE, no gen_done.
REQ-030 load and step in the same cycle SHALL load only.
REQ-031 run deasserting mid-generation SHALL NOT abort it; the generation completes.
REQ-032 Extinct boards SHALL still be evaluated; gen_count keeps incrementing.

Reset
REQ-033 On reset, while asserted: state=IDLE, board_out=SEED, prev=0, next=0, idx=0, frame_cnt=0, gen_count=0, gen_done=0, busy=0, extinct=(SEED==0), vsync_q=1.
REQ-034 vsync_q resetting to 1 SHALL prevent a spurious edge if vsync is high at reset release.
REQ-035 Reset asserted mid-sweep SHALL discard all partial results immediately.

Verification
REQ-036 Blinker: SEED=bits{27,28,29}, FRAMES_PER_GEN=1, run=1, one vsync edge -> gen_done 67 cycles later, board_out=bits{20,28,36}, gen_count=1; a second edge returns the original board.
REQ-037 Block still life {0,1,8,9} at the corner, 5 steps -> board unchanged after each step, gen_count=5, corner cells never wrap to 7/56/63.
REQ-038 Divider: FRAMES_PER_GEN=3, run=1, 9 edges spaced more than 67 cycles apart -> exactly 3 gen_done pulses, on edges 3, 6 and 9; run=0 -> no pulses.
REQ-039 Single-cell SEED bit 0, step -> board_out=0 and extinct=1 at COMMIT; later steps keep gen_count counting.
REQ-040 load pulsed at SWEEP idx=30 -> next cycle board_out=SEED, gen_count=0, busy=0, no gen_done; a step during busy is ignored.
REQ-041 Reset asserted mid-sweep, released -> outputs at their reset values; vsync held high through release produces no trigger.
